// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, exception causes and
// the stall/flush bundle driven to the four pipeline registers.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pipe_state_e;

  typedef enum logic [2:0] {
    NO_EXP     = 3'd0,
    EXT_INT    = 3'd1,
    UNDEF      = 3'd2,
    OVERFLOW   = 3'd3,
    MISS_ALIGN = 3'd4,
    TRAP       = 3'd5,
    PRV_VIO    = 3'd6
  } exp_code_e;

  // Bit order within each field: [3]=IF/ID, [2]=ID/EX, [1]=EX/MEM, [0]=MEM/WB
  typedef struct packed {
    logic [3:0] stall;
    logic [3:0] flush;
  } pipe_ctrl_bus_t;

endpackage

// File: rtl/pipe_ctrl_bus_watchdog.sv
// Bus-hang watchdog: counts consecutive mem_busy cycles and pulses
// bus_timeout every BUSY_TIMEOUT-th busy cycle.
module bus_watchdog #(
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_busy,
  output logic bus_timeout
);

  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BUSY_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_comb begin
    bus_timeout = mem_busy && (count == LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!mem_busy || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall/flush, load-use bubbles, and the
// exception/interrupt/ERET freeze-then-flush redirect sequence.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned           WORD_ADDR_W  = 30,
  parameter logic [WORD_ADDR_W-1:0] EXP_VECTOR  = 'h0000_0040,
  parameter int unsigned           BUSY_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_busy,
  input  logic                   mem_busy,
  input  logic                   ld_hazard,
  input  logic                   mem_en,
  input  logic [WORD_ADDR_W-1:0] mem_pc,
  input  logic [2:0]             mem_exp_code,
  input  logic                   mem_eret,
  input  logic                   int_req,
  input  logic                   int_en,
  output logic                   if_stall,
  output logic                   id_stall,
  output logic                   ex_stall,
  output logic                   mem_stall,
  output logic                   if_flush,
  output logic                   id_flush,
  output logic                   ex_flush,
  output logic                   mem_flush,
  output logic [WORD_ADDR_W-1:0] new_pc,
  output logic [WORD_ADDR_W-1:0] epc,
  output logic [2:0]             exp_code,
  output logic                   exp_active,
  output logic                   bus_timeout
);

  pipe_state_e    state, next_state;
  pipe_ctrl_bus_t ctrl;
  logic           busy;
  logic           take_trap;
  logic           take_eret;
  logic [2:0]     cause;
  logic           eret_pend;

  always_comb begin
    busy       = if_busy | mem_busy;
    next_state = state;
    ctrl       = '0;
    new_pc     = '0;
    take_trap  = 1'b0;
    take_eret  = 1'b0;
    cause      = NO_EXP;
    case (state)
      RUN: begin
        if (mem_en && mem_exp_code != NO_EXP) begin
          take_trap = 1'b1;
          cause     = mem_exp_code;
        end else if (mem_en && mem_eret) begin
          take_eret = 1'b1;
        end else if (mem_en && int_req && int_en && !exp_active) begin
          take_trap = 1'b1;
          cause     = EXT_INT;
        end
        if (take_trap || take_eret) begin
          ctrl.stall = '1;
          next_state = FLUSH;
        end else begin
          ctrl.stall    = {busy | ld_hazard, busy, busy, busy};
          ctrl.flush[2] = ld_hazard & ~busy;
        end
      end
      FLUSH: begin
        if (busy) begin
          ctrl.stall = '1;
        end else begin
          ctrl.flush = '1;
          new_pc     = eret_pend ? epc : EXP_VECTOR;
          next_state = RUN;
        end
      end
    endcase
  end

  always_comb begin
    {if_stall, id_stall, ex_stall, mem_stall} = ctrl.stall;
    {if_flush, id_flush, ex_flush, mem_flush} = ctrl.flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      epc        <= '0;
      exp_code   <= '0;
      exp_active <= 1'b0;
      eret_pend  <= 1'b0;
    end else begin
      state <= next_state;
      if (take_trap) begin
        epc        <= mem_pc;
        exp_code   <= cause;
        exp_active <= 1'b1;
        eret_pend  <= 1'b0;
      end else if (take_eret) begin
        eret_pend <= 1'b1;
      end else if (state == FLUSH && !busy) begin
        if (eret_pend) begin
          exp_active <= 1'b0;
        end
        eret_pend <= 1'b0;
      end
    end
  end

  bus_watchdog #(
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) u_bus_watchdog (
    .clk        (clk),
    .reset      (reset),
    .mem_busy   (mem_busy),
    .bus_timeout(bus_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, watchdog and
// reset sequences, then random stimulus against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned AW  = 30;
  localparam logic [29:0] VEC = 30'h40;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic if_busy, mem_busy, ld_hazard, mem_en, mem_eret, int_req, int_en;
  logic [AW-1:0] mem_pc;
  logic [2:0] mem_exp_code;
  logic if_stall, id_stall, ex_stall, mem_stall;
  logic if_flush, id_flush, ex_flush, mem_flush;
  logic [AW-1:0] new_pc, epc;
  logic [2:0] exp_code;
  logic exp_active, bus_timeout;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .WORD_ADDR_W (AW),
    .EXP_VECTOR  (VEC),
    .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
    .mem_en(mem_en), .mem_pc(mem_pc), .mem_exp_code(mem_exp_code),
    .mem_eret(mem_eret), .int_req(int_req), .int_en(int_en),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc), .epc(epc), .exp_code(exp_code), .exp_active(exp_active),
    .bus_timeout(bus_timeout)
  );

  wire [3:0] stall_o = {if_stall, id_stall, ex_stall, mem_stall};
  wire [3:0] flush_o = {if_flush, id_flush, ex_flush, mem_flush};

  typedef struct {
    logic ifb, memb, ldh, men, eret, ireq, ien;
    logic [29:0] pc;
    logic [2:0]  code;
  } in_t;

  typedef struct {
    in_t         in;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic [29:0] npc;
    logic        xa;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t mi(input logic ifb, memb, ldh, men, eret, ireq, ien,
                             input logic [29:0] pc, input logic [2:0] code);
    in_t v;
    v.ifb = ifb; v.memb = memb; v.ldh = ldh; v.men = men; v.eret = eret;
    v.ireq = ireq; v.ien = ien; v.pc = pc; v.code = code;
    return v;
  endfunction

  function automatic vec_t mv(input in_t in, input logic [3:0] s, f,
                              input logic [29:0] npc, input logic xa);
    vec_t r;
    r.in = in; r.stall = s; r.flush = f; r.npc = npc; r.xa = xa;
    return r;
  endfunction

  task automatic drive(input in_t v);
    if_busy = v.ifb; mem_busy = v.memb; ld_hazard = v.ldh; mem_en = v.men;
    mem_eret = v.eret; int_req = v.ireq; int_en = v.ien;
    mem_pc = v.pc; mem_exp_code = v.code;
  endtask

  // Behavioural model: a redirect is "owed" after an accepted event and is
  // paid on the first non-busy cycle; watchdog fires on every TMO-th busy cycle.
  logic        m_owed, m_to_handler, m_xa;
  logic [29:0] m_epc;
  logic [2:0]  m_code;
  int unsigned m_run;

  task automatic model_reset();
    m_owed = 0; m_to_handler = 0; m_xa = 0; m_epc = '0; m_code = '0; m_run = 0;
  endtask

  task automatic model_step(input in_t v, output logic [3:0] es, ef,
                            output logic [29:0] enpc, output logic eto);
    logic busy;
    busy = v.ifb | v.memb;
    es = 4'h0; ef = 4'h0; enpc = '0;
    if (!m_owed) begin
      if (v.men && v.code != 0) begin
        es = 4'hF; m_owed = 1; m_to_handler = 1; m_epc = v.pc; m_code = v.code; m_xa = 1;
      end else if (v.men && v.eret) begin
        es = 4'hF; m_owed = 1; m_to_handler = 0;
      end else if (v.men && v.ireq && v.ien && !m_xa) begin
        es = 4'hF; m_owed = 1; m_to_handler = 1; m_epc = v.pc; m_code = 3'd1; m_xa = 1;
      end else begin
        es = busy ? 4'hF : 4'h0;
        if (v.ldh) es[3] = 1'b1;
        ef[2] = v.ldh & ~busy;
      end
    end else if (busy) begin
      es = 4'hF;
    end else begin
      ef = 4'hF;
      enpc = m_to_handler ? VEC : m_epc;
      if (!m_to_handler) m_xa = 0;
      m_owed = 0;
    end
    eto = v.memb && ((m_run + 1) % TMO == 0);
    m_run = v.memb ? m_run + 1 : 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(mi(0, 0, 0, 0, 0, 0, 0, '0, '0));
    #2;
    chk("rst stall", {28'd0, stall_o}, 32'h0);
    chk("rst flush", {28'd0, flush_o}, 32'h0);
    chk("rst new_pc", {2'b0, new_pc}, 32'h0);
    chk("rst epc", {2'b0, epc}, 32'h0);
    chk("rst exp", {28'd0, exp_active, exp_code}, 32'h0);
    chk("rst bus_timeout", {31'd0, bus_timeout}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  vec_t tbl[25];

  initial begin
    logic [3:0]  es, ef;
    logic [29:0] enpc;
    logic        eto;
    in_t         v;

    tbl[0]  = mv(mi(0,0,0,0,0,0,0,'h0,0),   4'h0, 4'h0, 'h0,   0);
    tbl[1]  = mv(mi(0,0,1,0,0,0,0,'h0,0),   4'h8, 4'h4, 'h0,   0);
    tbl[2]  = mv(mi(0,0,0,0,0,0,0,'h0,0),   4'h0, 4'h0, 'h0,   0);
    tbl[3]  = mv(mi(0,1,1,0,0,0,0,'h0,0),   4'hF, 4'h0, 'h0,   0);
    tbl[4]  = mv(mi(0,0,0,1,0,0,0,'h100,3), 4'hF, 4'h0, 'h0,   0);
    tbl[5]  = mv(mi(0,0,0,0,0,0,0,'h0,0),   4'h0, 4'hF, 'h40,  1);
    tbl[6]  = mv(mi(0,0,0,0,0,0,0,'h0,0),   4'h0, 4'h0, 'h0,   1);
    tbl[7]  = mv(mi(0,0,0,1,0,0,0,'h200,5), 4'hF, 4'h0, 'h0,   1);
    tbl[8]  = mv(mi(0,1,0,0,0,0,0,'h0,0),   4'hF, 4'h0, 'h0,   1);
    tbl[9]  = mv(mi(0,1,0,0,0,0,0,'h0,0),   4'hF, 4'h0, 'h0,   1);
    tbl[10] = mv(mi(0,1,0,0,0,0,0,'h0,0),   4'hF, 4'h0, 'h0,   1);
    tbl[11] = mv(mi(0,0,0,0,0,0,0,'h0,0),   4'h0, 4'hF, 'h40,  1);
    tbl[12] = mv(mi(0,0,0,1,0,1,1,'h250,0), 4'h0, 4'h0, 'h0,   1);
    tbl[13] = mv(mi(0,0,0,1,1,0,0,'h300,0), 4'hF, 4'h0, 'h0,   1);
    tbl[14] = mv(mi(0,0,0,0,0,0,0,'h0,0),   4'h0, 4'hF, 'h200, 1);
    tbl[15] = mv(mi(0,0,0,1,0,1,1,'h180,0), 4'hF, 4'h0, 'h0,   0);
    tbl[16] = mv(mi(0,0,0,0,0,0,0,'h0,0),   4'h0, 4'hF, 'h40,  1);
    tbl[17] = mv(mi(0,0,0,1,1,0,0,'h140,2), 4'hF, 4'h0, 'h0,   1);
    tbl[18] = mv(mi(0,0,0,0,0,0,0,'h0,0),   4'h0, 4'hF, 'h40,  1);
    tbl[19] = mv(mi(0,0,0,0,1,0,0,'h0,4),   4'h0, 4'h0, 'h0,   1);
    tbl[20] = mv(mi(1,0,0,0,0,0,0,'h0,0),   4'hF, 4'h0, 'h0,   1);
    tbl[21] = mv(mi(0,0,0,1,1,0,0,'h44,0),  4'hF, 4'h0, 'h0,   1);
    tbl[22] = mv(mi(1,0,0,1,0,0,0,'h48,6),  4'hF, 4'h0, 'h0,   1);
    tbl[23] = mv(mi(0,0,1,1,0,1,1,'h4c,3),  4'h0, 4'hF, 'h140, 1);
    tbl[24] = mv(mi(0,0,0,0,0,0,0,'h0,0),   4'h0, 4'h0, 'h0,   0);

    do_reset();

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(tbl[i].in);
      #2;
      chk($sformatf("tbl%0d stall", i), {28'd0, stall_o}, {28'd0, tbl[i].stall});
      chk($sformatf("tbl%0d flush", i), {28'd0, flush_o}, {28'd0, tbl[i].flush});
      chk($sformatf("tbl%0d new_pc", i), {2'b0, new_pc}, {2'b0, tbl[i].npc});
      chk($sformatf("tbl%0d exp_active", i), {31'd0, exp_active}, {31'd0, tbl[i].xa});
      chk($sformatf("tbl%0d bus_timeout", i), {31'd0, bus_timeout}, 32'h0);
    end
    chk("tbl epc", {2'b0, epc}, 32'h140);
    chk("tbl exp_code", {29'd0, exp_code}, 32'd2);

    // Watchdog: 40 consecutive busy cycles, pulses on the 16th and 32nd
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      drive(mi(0, 1, 0, 0, 0, 0, 0, '0, '0));
      #2;
      chk($sformatf("wd%0d bus_timeout", i), {31'd0, bus_timeout},
          {31'd0, (i == 16 || i == 32) ? 1'b1 : 1'b0});
      chk($sformatf("wd%0d stall", i), {28'd0, stall_o}, 32'hF);
    end
    @(negedge clk);
    drive(mi(0, 0, 0, 0, 0, 0, 0, '0, '0));
    #2;
    chk("wd idle flush", {28'd0, flush_o}, 32'h0);
    chk("wd idle stall", {28'd0, stall_o}, 32'h0);

    // Reset asserted while FLUSH is held by a busy bus
    do_reset();
    @(negedge clk);
    drive(mi(0, 0, 0, 1, 0, 0, 0, 30'h123, 3'd4));
    #2;
    chk("mrst event stall", {28'd0, stall_o}, 32'hF);
    @(negedge clk);
    drive(mi(0, 1, 0, 0, 0, 0, 0, '0, '0));
    #2;
    chk("mrst hold stall", {28'd0, stall_o}, 32'hF);
    chk("mrst epc", {2'b0, epc}, 32'h123);
    #1;
    reset = 1'b0;
    drive(mi(0, 0, 0, 0, 0, 0, 0, '0, '0));
    #1;
    chk("mrst exp_active", {31'd0, exp_active}, 32'h0);
    chk("mrst epc cleared", {2'b0, epc}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("mrst no flush", {28'd0, flush_o}, 32'h0);
    chk("mrst no stall", {28'd0, stall_o}, 32'h0);

    // Random stimulus against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      v.ifb  = ($urandom % 8) == 0;
      v.memb = (($urandom % 6) == 0) || ((i % 200) >= 100 && (i % 200) < 120);
      v.ldh  = ($urandom % 4) == 0;
      v.men  = ($urandom % 3) == 0;
      v.eret = ($urandom % 4) == 0;
      v.ireq = $urandom % 2;
      v.ien  = $urandom % 2;
      v.pc   = 30'($urandom);
      v.code = (($urandom % 5) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
      @(negedge clk);
      drive(v);
      #2;
      chk($sformatf("rnd%0d epc", i), {2'b0, epc}, {2'b0, m_epc});
      chk($sformatf("rnd%0d exp_code", i), {29'd0, exp_code}, {29'd0, m_code});
      chk($sformatf("rnd%0d exp_active", i), {31'd0, exp_active}, {31'd0, m_xa});
      model_step(v, es, ef, enpc, eto);
      chk($sformatf("rnd%0d stall", i), {28'd0, stall_o}, {28'd0, es});
      chk($sformatf("rnd%0d flush", i), {28'd0, flush_o}, {28'd0, ef});
      chk($sformatf("rnd%0d new_pc", i), {2'b0, new_pc}, {2'b0, enpc});
      chk($sformatf("rnd%0d bus_timeout", i), {31'd0, bus_timeout}, {31'd0, eto});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
